// File: rtl/chain_score_reduce_if.sv
// Pair-in / group-result-out handshake bundle for chain_score_reduce.
// The slave side is the scoring unit; the master side is its producer/consumer.
interface chain_score_reduce_if #(
    parameter int unsigned W_COORD = 32,
    parameter int unsigned W_SCORE = 32,
    parameter int unsigned W_IDX   = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic                      in_last;
    logic [W_COORD-1:0]        riX;
    logic [W_COORD-1:0]        qiX;
    logic [W_COORD-1:0]        riY;
    logic [W_COORD-1:0]        qiY;
    logic [W_COORD-1:0]        w;
    logic signed [W_SCORE-1:0] pred_f;
    logic [W_IDX-1:0]          pred_idx;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [W_SCORE-1:0] out_best;
    logic [W_IDX-1:0]          out_idx;
    logic                      out_hit;

    modport master (
        output in_valid, in_last, riX, qiX, riY, qiY, w, pred_f, pred_idx, out_ready,
        input  in_ready, out_valid, out_best, out_idx, out_hit
    );

    modport slave (
        input  in_valid, in_last, riX, qiX, riY, qiY, w, pred_f, pred_idx, out_ready,
        output in_ready, out_valid, out_best, out_idx, out_hit
    );
endinterface

// File: rtl/chain_score_reduce.sv
// Anchor-chaining score unit: five-stage candidate pipeline feeding a per-group
// max-reducer, with a single global stall driven by the held output.
module chain_score_reduce #(
    parameter int unsigned W_COORD    = 32,
    parameter int unsigned W_SCORE    = 32,
    parameter int unsigned W_IDX      = 16,
    parameter int unsigned GAP_COEF   = 38,
    parameter int unsigned COEF_FRAC  = 8,
    parameter int unsigned MAX_DIST_R = 5000,
    parameter int unsigned MAX_DIST_Q = 5000
) (
    input logic                 clk,
    input logic                 reset,
    chain_score_reduce_if.slave bus
);

    localparam int unsigned WCoef = (GAP_COEF < 2) ? 1 : $clog2(GAP_COEF + 1);
    localparam int unsigned WProd = W_COORD + WCoef;
    localparam int unsigned WLg   = (W_COORD > 1) ? $clog2(W_COORD) : 1;
    localparam int unsigned WBeta = WProd + 1;
    // Wide enough that pred_f + alpha - beta can never wrap before saturation.
    localparam int unsigned WCand = ((W_SCORE > WBeta) ? W_SCORE : WBeta) + 2;

    localparam logic signed [WCand-1:0] SatMax =
        {{(WCand - W_SCORE + 1){1'b0}}, {(W_SCORE - 1){1'b1}}};
    localparam logic signed [WCand-1:0] SatMin =
        {{(WCand - W_SCORE + 1){1'b1}}, {(W_SCORE - 1){1'b0}}};

    typedef struct packed {
        logic               v;
        logic               last;
        logic               elig;
        logic [W_IDX-1:0]   idx;
        logic [W_SCORE-1:0] pf;
        logic [W_COORD-1:0] w;
        logic [W_COORD-1:0] dr;
        logic [W_COORD-1:0] dq;
    } s1_t;

    typedef struct packed {
        logic               v;
        logic               last;
        logic               elig;
        logic [W_IDX-1:0]   idx;
        logic [W_SCORE-1:0] pf;
        logic [W_COORD-1:0] w;
        logic [W_COORD-1:0] dd;
        logic [W_COORD-1:0] alpha;
    } s2_t;

    typedef struct packed {
        logic               v;
        logic               last;
        logic               elig;
        logic [W_IDX-1:0]   idx;
        logic [W_SCORE-1:0] pf;
        logic [W_COORD-1:0] w;
        logic [W_COORD-1:0] alpha;
        logic               dd_zero;
        logic [WProd-1:0]   prod;
        logic [WLg-1:0]     lg;
    } s3_t;

    typedef struct packed {
        logic               v;
        logic               last;
        logic               elig;
        logic [W_IDX-1:0]   idx;
        logic [W_COORD-1:0] w;
        logic [W_SCORE-1:0] cand;
    } s4_t;

    typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    s3_t s3_d, s3_q;
    s4_t s4_d, s4_q;

    state_e                    state_d, state_q;
    logic signed [W_SCORE-1:0] best_d, best_q;
    logic [W_IDX-1:0]          bidx_d, bidx_q;
    logic                      bhit_d, bhit_q;
    logic signed [W_SCORE-1:0] obest_d, obest_q;
    logic [W_IDX-1:0]          oidx_d, oidx_q;
    logic                      ohit_d, ohit_q;

    logic en;

    assign bus.out_valid = (state_q == StHold);
    assign en            = !(bus.out_valid && !bus.out_ready);
    assign bus.in_ready  = en;
    assign bus.out_best  = obest_q;
    assign bus.out_idx   = oidx_q;
    assign bus.out_hit   = ohit_q;

    // S1: raw distances and screening.
    always_comb begin
        s1_d = s1_q;
        if (en) begin
            s1_d.v    = bus.in_valid;
            s1_d.last = bus.in_last;
            s1_d.idx  = bus.pred_idx;
            s1_d.pf   = bus.pred_f;
            s1_d.w    = bus.w;
            s1_d.dr   = bus.riX - bus.riY;
            s1_d.dq   = bus.qiX - bus.qiY;
            s1_d.elig = (bus.riX > bus.riY) && (bus.qiX > bus.qiY) &&
                        (s1_d.dr <= W_COORD'(MAX_DIST_R)) &&
                        (s1_d.dq <= W_COORD'(MAX_DIST_Q));
        end
    end

    // S2: diagonal difference and alpha.
    always_comb begin
        logic [W_COORD-1:0] mn;
        s2_d = s2_q;
        mn   = (s1_q.dr < s1_q.dq) ? s1_q.dr : s1_q.dq;
        if (en) begin
            s2_d.v     = s1_q.v;
            s2_d.last  = s1_q.last;
            s2_d.elig  = s1_q.elig;
            s2_d.idx   = s1_q.idx;
            s2_d.pf    = s1_q.pf;
            s2_d.w     = s1_q.w;
            s2_d.dd    = (s1_q.dr >= s1_q.dq) ? (s1_q.dr - s1_q.dq) : (s1_q.dq - s1_q.dr);
            s2_d.alpha = (mn < s1_q.w) ? mn : s1_q.w;
        end
    end

    // S3: full-width gap product and floor(log2(dd)).
    always_comb begin
        logic [WLg-1:0] lg;
        s3_d = s3_q;
        lg   = '0;
        for (int i = 0; i < int'(W_COORD); i++) begin
            if (s2_q.dd[i]) lg = WLg'(i);
        end
        if (en) begin
            s3_d.v       = s2_q.v;
            s3_d.last    = s2_q.last;
            s3_d.elig    = s2_q.elig;
            s3_d.idx     = s2_q.idx;
            s3_d.pf      = s2_q.pf;
            s3_d.w       = s2_q.w;
            s3_d.alpha   = s2_q.alpha;
            s3_d.dd_zero = (s2_q.dd == '0);
            s3_d.prod    = WProd'(s2_q.dd) * WProd'(GAP_COEF);
            s3_d.lg      = lg;
        end
    end

    // S4: beta and saturated candidate.
    always_comb begin
        logic [WBeta-1:0]        beta;
        logic signed [WCand-1:0] cw;
        s4_d = s4_q;
        beta = s3_q.dd_zero ? '0 :
               (WBeta'(s3_q.prod >> COEF_FRAC) + WBeta'(s3_q.lg >> 1));
        cw   = WCand'($signed(s3_q.pf))
             + $signed({{(WCand - W_COORD){1'b0}}, s3_q.alpha})
             - $signed({{(WCand - WBeta){1'b0}}, beta});
        if (en) begin
            s4_d.v    = s3_q.v;
            s4_d.last = s3_q.last;
            s4_d.elig = s3_q.elig;
            s4_d.idx  = s3_q.idx;
            s4_d.w    = s3_q.w;
            if (cw > SatMax)      s4_d.cand = SatMax[W_SCORE-1:0];
            else if (cw < SatMin) s4_d.cand = SatMin[W_SCORE-1:0];
            else                  s4_d.cand = cw[W_SCORE-1:0];
        end
    end

    // S5: group reducer. Anything other than an open group starts from a fresh seed.
    always_comb begin
        logic                      fresh;
        logic                      upd;
        logic signed [W_SCORE-1:0] base_best;
        logic [W_IDX-1:0]          base_idx;
        logic                      base_hit;
        logic signed [W_SCORE-1:0] new_best;
        logic [W_IDX-1:0]          new_idx;
        logic                      new_hit;

        state_d = state_q;
        best_d  = best_q;
        bidx_d  = bidx_q;
        bhit_d  = bhit_q;
        obest_d = obest_q;
        oidx_d  = oidx_q;
        ohit_d  = ohit_q;

        fresh     = (state_q != StAcc);
        base_best = fresh ? $signed(W_SCORE'(s4_q.w)) : best_q;
        base_idx  = fresh ? '1 : bidx_q;
        base_hit  = fresh ? 1'b0 : bhit_q;
        upd       = s4_q.elig && ($signed(s4_q.cand) > base_best);
        new_best  = upd ? $signed(s4_q.cand) : base_best;
        new_idx   = upd ? s4_q.idx : base_idx;
        new_hit   = upd | base_hit;

        if (en) begin
            // en high while holding means out_ready accepted the result this cycle.
            if (state_q == StHold) state_d = StIdle;
            if (s4_q.v) begin
                if (s4_q.last) begin
                    obest_d = new_best;
                    oidx_d  = new_idx;
                    ohit_d  = new_hit;
                    state_d = StHold;
                end else begin
                    best_d  = new_best;
                    bidx_d  = new_idx;
                    bhit_d  = new_hit;
                    state_d = StAcc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            s4_q    <= '0;
            state_q <= StIdle;
            best_q  <= '0;
            bidx_q  <= '0;
            bhit_q  <= 1'b0;
            obest_q <= '0;
            oidx_q  <= '0;
            ohit_q  <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            s4_q    <= s4_d;
            state_q <= state_d;
            best_q  <= best_d;
            bidx_q  <= bidx_d;
            bhit_q  <= bhit_d;
            obest_q <= obest_d;
            oidx_q  <= oidx_d;
            ohit_q  <= ohit_d;
        end
    end

endmodule

// File: tb/tb_chain_score_reduce.sv
// Scoreboard bench for chain_score_reduce: a behavioural group model pushes expected
// results as pairs are driven; a negedge monitor pops and compares emitted results.
module tb_chain_score_reduce;

    typedef struct {
        longint best;
        longint idx;
        longint hit;
    } exp_t;

    logic clk;
    logic reset;

    chain_score_reduce_if #(.W_COORD(32), .W_SCORE(32), .W_IDX(16)) bus ();

    chain_score_reduce dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_errors = 0;
    exp_t   sb[$];
    bit     gopen = 0;
    longint gbest, gidx, ghit;

    task automatic check_val(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic longint ilog2(input longint v);
        longint r = 0;
        while (v > 1) begin
            v = v >> 1;
            r++;
        end
        return r;
    endfunction

    function automatic void model_cand(input longint rix, input longint qix, input longint riy,
                                       input longint qiy, input longint w, input longint pf,
                                       output bit elig, output longint cand);
        longint dr, dq, dd, mn, alpha, beta;
        dr    = rix - riy;
        dq    = qix - qiy;
        elig  = (rix > riy) && (qix > qiy) && (dr <= 5000) && (dq <= 5000);
        dd    = (dr > dq) ? dr - dq : dq - dr;
        mn    = (dr < dq) ? dr : dq;
        alpha = (mn < w) ? mn : w;
        beta  = (dd == 0) ? 0 : (((dd * 38) >> 8) + (ilog2(dd) >> 1));
        cand  = pf + alpha - beta;
        if (cand > 64'sd2147483647) cand = 64'sd2147483647;
        if (cand < -64'sd2147483648) cand = -64'sd2147483648;
    endfunction

    // Drive one pair, wait (bounded) for acceptance, and fold it into the model group.
    task automatic send(input longint rix, input longint qix, input longint riy,
                        input longint qiy, input longint w, input longint pf,
                        input int idx, input bit last);
        bit     acc;
        bit     elig;
        longint cand;
        int     n = 0;
        bus.riX      = rix[31:0];
        bus.qiX      = qix[31:0];
        bus.riY      = riy[31:0];
        bus.qiY      = qiy[31:0];
        bus.w        = w[31:0];
        bus.pred_f   = pf[31:0];
        bus.pred_idx = idx[15:0];
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            n++;
        end while (!acc && n < 200);
        #1 bus.in_valid = 1'b0;
        if (!acc) check_val("accept_timeout", 0, 1);
        model_cand(rix, qix, riy, qiy, w, pf, elig, cand);
        if (!gopen) begin
            gbest = w;
            gidx  = 16'hffff;
            ghit  = 0;
            gopen = 1;
        end
        if (elig && cand > gbest) begin
            gbest = cand;
            gidx  = idx;
            ghit  = 1;
        end
        if (last) begin
            sb.push_back('{best: gbest, idx: gidx, hit: ghit});
            gopen = 0;
        end
    endtask

    // Output monitor: stability under stall, in_ready during stall, scoreboard pops.
    bit          prev_stall = 0;
    logic [31:0] p_best;
    logic [15:0] p_idx;
    logic        p_hit;

    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check_val("stall_valid", longint'(bus.out_valid), 1);
                check_val("stall_best", longint'(bus.out_best), longint'(p_best));
                check_val("stall_idx", longint'(bus.out_idx), longint'(p_idx));
                check_val("stall_hit", longint'(bus.out_hit), longint'(p_hit));
            end
            if (bus.out_valid && !bus.out_ready) begin
                check_val("stall_in_ready", longint'(bus.in_ready), 0);
                prev_stall = 1;
                p_best     = bus.out_best;
                p_idx      = bus.out_idx;
                p_hit      = bus.out_hit;
            end else begin
                prev_stall = 0;
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        check_val("unexpected_out", 1, 0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check_val("out_best", longint'($signed(bus.out_best)), e.best);
                        check_val("out_idx", longint'(bus.out_idx), e.idx);
                        check_val("out_hit", longint'(bus.out_hit), e.hit);
                    end
                end
            end
        end
    end

    task automatic check_idle_regs(input string tag);
        check_val({tag, "_out_valid"}, longint'(bus.out_valid), 0);
        check_val({tag, "_out_best"}, longint'(bus.out_best), 0);
        check_val({tag, "_out_idx"}, longint'(bus.out_idx), 0);
        check_val({tag, "_out_hit"}, longint'(bus.out_hit), 0);
        check_val({tag, "_in_ready"}, longint'(bus.in_ready), 1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, longint'(sb.size()), 0);
    endtask

    initial begin
        int k;
        bit rnd_ready;
        bus.in_valid  = 0;
        bus.in_last   = 0;
        bus.riX       = '0;
        bus.qiX       = '0;
        bus.riY       = '0;
        bus.qiY       = '0;
        bus.w         = '0;
        bus.pred_f    = '0;
        bus.pred_idx  = '0;
        bus.out_ready = 1;
        reset         = 0;
        repeat (3) @(negedge clk);
        check_idle_regs("reset");
        reset = 1;
        @(posedge clk);
        #1;

        // Diagonal pair (dd == 0) with latency measurement.
        send(1000, 500, 900, 400, 15, 40, 5, 1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.out_valid && k < 20);
        check_val("latency", k, 5);
        drain("drain_dd0");
        @(posedge clk);
        #1;

        // Gap penalty: dd = 20, beta = 2 + 2.
        send(1000, 500, 900, 420, 15, 40, 2, 1);
        drain("drain_gap");
        @(posedge clk);
        #1;

        // Reduction with a tie: first of the equal candidates wins.
        send(1000, 500, 900, 420, 15, 40, 3, 0);
        send(1000, 500, 900, 400, 15, 40, 7, 0);
        send(1000, 500, 900, 400, 15, 40, 9, 1);
        // All ineligible: riY >= riX, then dr = 6000.
        send(1000, 500, 1100, 400, 15, 40, 1, 0);
        send(7000, 500, 1000, 400, 15, 40, 2, 1);
        drain("drain_reduce");
        @(posedge clk);
        #1;

        // Backpressure: hold the first result while two more groups stream in.
        bus.out_ready = 0;
        fork
            begin
                send(1000, 500, 900, 400, 15, 10, 11, 1);
                send(1000, 500, 900, 420, 15, 20, 12, 0);
                send(1000, 500, 900, 400, 15, 25, 13, 1);
                send(2000, 900, 1990, 880, 30, -5, 14, 1);
            end
            begin
                k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (!bus.out_valid && k < 50);
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1;
            end
        join
        drain("drain_bp");
        @(posedge clk);
        #1;

        // Saturation at the positive limit.
        send(1000, 500, 900, 400, 15, 2147483638, 21, 1);
        drain("drain_sat");
        @(posedge clk);
        #1;

        // Reset in the middle of a group: nothing may be emitted for it.
        send(1000, 500, 900, 400, 15, 40, 30, 0);
        send(1000, 500, 900, 400, 15, 50, 31, 0);
        #2 reset = 0;
        gopen = 0;
        repeat (2) @(negedge clk);
        check_idle_regs("midreset");
        reset = 1;
        repeat (8) @(negedge clk);
        check_val("midreset_no_out", longint'(bus.out_valid), 0);
        @(posedge clk);
        #1;
        send(1000, 500, 900, 420, 15, 40, 40, 0);
        send(1000, 500, 900, 400, 15, 60, 41, 1);
        drain("drain_post_reset");
        @(posedge clk);
        #1;

        // Random groups under random output backpressure.
        fork
            begin
                for (int g = 0; g < 8; g++) begin
                    int np;
                    np = $urandom_range(1, 4);
                    for (int p = 0; p < np; p++) begin
                        longint rix, qix;
                        rix = 10000 + $urandom_range(0, 3000);
                        qix = 10000 + $urandom_range(0, 3000);
                        send(rix, qix, rix - $urandom_range(0, 6000),
                             qix - $urandom_range(0, 6000), $urandom_range(5, 60),
                             longint'($urandom_range(0, 200)) - 100, g * 8 + p, p == np - 1);
                    end
                end
                rnd_ready = 0;
            end
            begin
                rnd_ready = 1;
                while (rnd_ready) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(0, 2) != 0);
                end
                bus.out_ready = 1;
            end
        join
        drain("drain_random");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/chain_score_reduce.md
# chain_score_reduce

Parametrised anchor-chaining score unit with backpressure. It streams (current anchor, predecessor) pairs, computes each pair's gap-penalised chaining candidate, and reduces each group of pairs to the best predecessor. The group for anchor i ends on the pair flagged `in_last`, and the unit then emits f[i] = max(w, max_j(f[j] + alpha − beta)) together with the winning predecessor index. It sits between the predecessor fetch stage and the chain-score writeback in the chaining datapath. It supersedes the fixed 32-bit, non-reducing score pipeline.

## Interface
- `W_COORD`, 32: coordinate width (unsigned).
- `W_SCORE`, 32: score width (signed two's complement).
- `W_IDX`, 16: predecessor index width.
- `GAP_COEF`, 38: linear gap coefficient, unsigned fixed point.
- `COEF_FRAC`, 8: fractional bits of `GAP_COEF`; the default is ≈0.15.
- `MAX_DIST_R`, 5000: maximum reference distance dr.
- `MAX_DIST_Q`, 5000: maximum query distance dq.
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: pair valid.
- `in_ready` out 1: pair accepted when `in_valid && in_ready`.
- `in_last` in 1: last pair of the current anchor's group.
- `riX`, `qiX` in W_COORD: current anchor reference and query positions.
- `riY`, `qiY` in W_COORD: predecessor reference and query positions.
- `w` in W_COORD: current anchor span (seed length).
- `pred_f` in W_SCORE: predecessor chain score f[j].
- `pred_idx` in W_IDX: predecessor index j.
- `out_valid` out 1: group result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_best` out W_SCORE: f[i].
- `out_idx` out W_IDX: winning j, or all-ones if no predecessor won.
- `out_hit` out 1: 1 if some predecessor beat w.

## Operation
- **Pair screening.** Compute dr = riX − riY and dq = qiX − qiY.
  - The pair is eligible only if riX > riY, qiX > qiY, dr ≤ MAX_DIST_R and dq ≤ MAX_DIST_Q.
  - An ineligible pair still occupies a pipeline slot and still honours `in_last`, but it never updates the best.
- **Candidate arithmetic.**
  - dd = |dr − dq|, computed without wrap.
  - mn = min(dr, dq).
  - alpha = min(mn, w).
  - beta = 0 if dd == 0; otherwise ((dd · GAP_COEF) >> COEF_FRAC) + (ilog2(dd) >> 1).
  - ilog2 is floor(log2); ilog2(1) = 0.
  - The product is W_COORD + bits(GAP_COEF) wide, with no truncation before the shift.
  - cand = pred_f + alpha − beta. Evaluate it at W_SCORE+2 bits, then saturate to [−2^(W_SCORE−1), 2^(W_SCORE−1) − 1].
- **Reduction state machine.** States are IDLE, ACC and HOLD.
  - IDLE: no group is open. The first pair's candidate arriving at the reducer seeds best = w (zero-extended to W_SCORE), idx = all-ones, hit = 0. The reducer then compares that candidate against the seed.
  - Compare rule: replace only if the candidate is eligible and cand > best (strictly greater). On a tie, the earlier pair is kept.
  - ACC → ACC on each non-last pair.
  - On a pair with `in_last` set, the reducer loads the output registers, goes to HOLD and asserts `out_valid`.
  - HOLD → IDLE when `out_ready` is high. If the next group's first candidate arrives in that same cycle, the reducer goes directly to ACC with a fresh seed.
  - A single-pair group (`in_last` on the first pair) is legal.
- **Backpressure.**
  - Global advance: `en = !(out_valid && !out_ready)`.
  - `in_ready = en`. All pipeline and reducer registers hold while `en` is low.
  - `out_*` must stay stable while `out_valid && !out_ready`.
- **Reset.** Reset during operation discards all in-flight pairs and any partial group, and returns the FSM to IDLE.

## Timing
- Reset values: `out_valid` = 0, `out_best` = 0, `out_idx` = 0, `out_hit` = 0, `in_ready` = 1, all pipeline valids = 0.
- Pipeline stages, each one register:
  - S1: dr, dq, eligibility.
  - S2: dd, mn, alpha.
  - S3: product and ilog2.
  - S4: beta and saturated cand.
  - S5: reducer and output.
- Latency: if the last pair is accepted in cycle t, `out_valid` rises in cycle t+5. Stall cycles add one-for-one.
- Throughput: one pair per cycle when not stalled.
- `in_last` and `pred_idx` travel with their pair's valid through S1–S4.

## Test plan
- **dd = 0 pair.** One pair with riX=1000, riY=900, qiX=500, qiY=400, w=15, pred_f=40, last=1. Required: `out_best`=55, `out_idx`=pred_idx, `out_hit`=1, `out_valid` at t+5.
- **Gap penalty.** Same pair but qiY=420 (dq=80, dd=20). Required: beta = 2 + 2 = 4, `out_best`=51.
- **Reduction with a tie.** A 3-pair group whose candidates are 51 (idx 3), 55 (idx 7) and 55 (idx 9). Required: `out_best`=55, `out_idx`=7.
- **All ineligible.** riY ≥ riX on one pair and dr=6000 on the other, with w=15. Required: `out_best`=15, `out_idx`=all-ones, `out_hit`=0.
- **Backpressure.** Hold `out_ready`=0 for 4 cycles while two more groups stream in. Required: `in_ready` low during the stall, `out_*` stable, no result lost or duplicated, and both later groups emitted in order.
- **Saturation and reset.** pred_f = 2^31−10 with alpha=15, beta=0. Required: `out_best` = 2^31−1. Assert `reset` mid-group. Required: no output, and the next full group produces correct results.
